// File: rtl/pe_wavefront_scheduler_if.sv
// Host-side control bundle for the PE wavefront scheduler: run request,
// per-run enable length and the scheduler's idle/ready indication.
interface pe_wavefront_scheduler_if #(
    parameter int LEN_BITS = 16
);
    logic                host_start;
    logic [LEN_BITS-1:0] host_len;
    logic                host_ready;

    // Host side: issues runs and watches for the scheduler to go idle
    modport master (
        output host_start,
        output host_len,
        input  host_ready
    );

    // Scheduler side: accepts runs while idle
    modport slave (
        input  host_start,
        input  host_len,
        output host_ready
    );
endinterface

// File: rtl/pe_wavefront_scheduler.sv
// Staggered ap_start sequencer for a chain of pass-through PE tiles.
// Tile i sees its enable window open STAGGER*i non-stalled cycles after
// tile 0 and stay open for the host-programmed length L. A stall freezes
// the whole wavefront and masks every enable for that cycle.
module pe_wavefront_scheduler #(
    parameter  int NUM_TILES = 4,
    parameter  int STAGGER   = 2,
    parameter  int LEN_BITS  = 16,
    localparam int CNT_BITS  = LEN_BITS + $clog2(NUM_TILES * STAGGER + 1) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    pe_wavefront_scheduler_if.slave     host,
    input  logic                        stall,
    output logic [NUM_TILES-1:0]        tile_ap_start,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_BITS-1:0]         run_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Offset of the last tile's window; the run ends once it has closed.
    localparam int LAST_OFFSET = (NUM_TILES - 1) * STAGGER;

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] run_cnt_q, run_cnt_d;
    logic [LEN_BITS-1:0] len_q, len_d;

    logic [CNT_BITS-1:0] len_ext;
    logic [CNT_BITS-1:0] total;

    assign len_ext = CNT_BITS'(len_q);
    assign total   = CNT_BITS'(LAST_OFFSET) + len_ext;

    // State, counter and latched length registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            run_cnt_q <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            len_q     <= len_d;
        end
    end

    // Next-state logic: accept in IDLE, count non-stalled cycles in RUN, one-cycle DONE
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        len_d     = len_q;
        case (state_q)
            IDLE: begin
                if (host.host_start) begin
                    len_d     = host.host_len;
                    run_cnt_d = '0;
                    state_d   = (host.host_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    run_cnt_d = run_cnt_q + 1'b1;
                    if (run_cnt_q == total - 1'b1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-tile enable windows, masked by stall in the same cycle
    always_comb begin
        tile_ap_start = '0;
        if ((state_q == RUN) && !stall) begin
            for (int i = 0; i < NUM_TILES; i++) begin
                if ((run_cnt_q >= CNT_BITS'(i * STAGGER)) &&
                    (run_cnt_q <  CNT_BITS'(i * STAGGER) + len_ext)) begin
                    tile_ap_start[i] = 1'b1;
                end
            end
        end
    end

    assign host.host_ready = (state_q == IDLE);
    assign busy            = (state_q == RUN);
    assign done            = (state_q == DONE);
    assign run_cnt         = run_cnt_q;

endmodule

// File: tb/tb_pe_wavefront_scheduler.sv
// Scoreboard bench for pe_wavefront_scheduler. Two instances share the same
// host/stall/reset stimulus: one with STAGGER=2 and one with STAGGER=0.
// A reference model derived from the run rules predicts every cycle's
// outputs; a negedge monitor pops and compares them.
module tb_pe_wavefront_scheduler;

    localparam int LEN_BITS = 16;
    localparam int NT       = 4;
    localparam int SA       = 2;
    localparam int SB       = 0;
    localparam int CW_A     = LEN_BITS + $clog2(NT * SA + 1) + 1;
    localparam int CW_B     = LEN_BITS + $clog2(NT * SB + 1) + 1;

    // Abstract run phase used by the reference model
    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;

    typedef struct {
        bit known;
        int ph;
        int elapsed;
        int len;
    } mdl_t;

    typedef struct {
        bit            chk;
        logic [NT-1:0] tiles;
        bit            busy;
        bit            ready;
        bit            done;
        int            cnt;
    } exp_t;

    typedef struct {
        int   cyc;
        exp_t a;
        exp_t b;
    } pair_t;

    logic clk = 1'b0;
    logic reset;
    logic stall;

    logic [NT-1:0]   tiles_a, tiles_b;
    logic            busy_a, busy_b, done_a, done_b;
    logic [CW_A-1:0] cnt_a;
    logic [CW_B-1:0] cnt_b;

    pe_wavefront_scheduler_if #(.LEN_BITS(LEN_BITS)) hif_a ();
    pe_wavefront_scheduler_if #(.LEN_BITS(LEN_BITS)) hif_b ();

    pe_wavefront_scheduler #(.NUM_TILES(NT), .STAGGER(SA), .LEN_BITS(LEN_BITS)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .host          (hif_a.slave),
        .stall         (stall),
        .tile_ap_start (tiles_a),
        .busy          (busy_a),
        .done          (done_a),
        .run_cnt       (cnt_a)
    );

    pe_wavefront_scheduler #(.NUM_TILES(NT), .STAGGER(SB), .LEN_BITS(LEN_BITS)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .host          (hif_b.slave),
        .stall         (stall),
        .tile_ap_start (tiles_b),
        .busy          (busy_b),
        .done          (done_b),
        .run_cnt       (cnt_b)
    );

    always #5 clk = ~clk;

    pair_t sb_q[$];
    mdl_t  ma, mb;
    int    cyc;
    int    n_compared;
    int    n_mismatched;

    // Expected outputs for the current cycle, from the run rules
    function automatic exp_t mdlOut(input mdl_t m, input bit stl, input int stg);
        exp_t e;
        e.chk   = m.known;
        e.tiles = '0;
        e.busy  = (m.ph == PH_RUN);
        e.ready = (m.ph == PH_IDLE);
        e.done  = (m.ph == PH_DONE);
        e.cnt   = m.elapsed;
        if (m.ph == PH_RUN && !stl) begin
            for (int i = 0; i < NT; i++) begin
                if (m.elapsed >= i * stg && m.elapsed < i * stg + m.len) e.tiles[i] = 1'b1;
            end
        end
        return e;
    endfunction

    // Advance the model across one clock edge
    function automatic mdl_t mdlStep(input mdl_t m, input bit rst_n, input bit start,
                                     input int len, input bit stl, input int stg);
        mdl_t n = m;
        if (!rst_n) begin
            n.known   = 1'b1;
            n.ph      = PH_IDLE;
            n.elapsed = 0;
            n.len     = 0;
        end else if (m.known) begin
            if (m.ph == PH_IDLE) begin
                if (start) begin
                    n.len     = len;
                    n.elapsed = 0;
                    n.ph      = (len == 0) ? PH_DONE : PH_RUN;
                end
            end else if (m.ph == PH_RUN) begin
                if (!stl) begin
                    n.elapsed = m.elapsed + 1;
                    if (n.elapsed == (NT - 1) * stg + m.len) n.ph = PH_DONE;
                end
            end else begin
                n.ph = PH_IDLE;
            end
        end
        return n;
    endfunction

    task automatic cmpOne(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int c, input exp_t e,
                               input logic [NT-1:0] t, input logic b, input logic r,
                               input logic d, input logic [63:0] cnt);
        if (e.chk) begin
            cmpOne({tag, ".tile_ap_start"}, c, 64'(t), 64'(e.tiles));
            cmpOne({tag, ".busy"},          c, 64'(b), 64'(e.busy));
            cmpOne({tag, ".host_ready"},    c, 64'(r), 64'(e.ready));
            cmpOne({tag, ".done"},          c, 64'(d), 64'(e.done));
            cmpOne({tag, ".run_cnt"},       c, cnt,    64'(e.cnt));
        end
    endtask

    // One cycle of stimulus: drive inputs after the edge, queue the prediction
    task automatic applyStimulus(input bit rst_n, input bit start, input int len, input bit stl);
        pair_t p;
        @(posedge clk);
        #1;
        reset            = rst_n;
        stall            = stl;
        hif_a.host_start = start;
        hif_b.host_start = start;
        hif_a.host_len   = len[LEN_BITS-1:0];
        hif_b.host_len   = len[LEN_BITS-1:0];
        p.cyc = cyc;
        p.a   = mdlOut(ma, stl, SA);
        p.b   = mdlOut(mb, stl, SB);
        sb_q.push_back(p);
        ma = mdlStep(ma, rst_n, start, len, stl, SA);
        mb = mdlStep(mb, rst_n, start, len, stl, SB);
        cyc++;
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    endtask

    // Monitor: compare both instances against the queued prediction
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            pair_t p;
            p = sb_q.pop_front();
            checkOutput("A", p.cyc, p.a, tiles_a, busy_a, hif_a.host_ready, done_a, 64'(cnt_a));
            checkOutput("B", p.cyc, p.b, tiles_b, busy_b, hif_b.host_ready, done_b, 64'(cnt_b));
        end
    end

    initial begin
        n_compared       = 0;
        n_mismatched     = 0;
        cyc              = 0;
        ma               = '{known: 1'b0, ph: 0, elapsed: 0, len: 0};
        mb               = ma;
        reset            = 1'b0;
        stall            = 1'b0;
        hif_a.host_start = 1'b0;
        hif_b.host_start = 1'b0;
        hif_a.host_len   = '0;
        hif_b.host_len   = '0;

        $display("[TB] reset and basic run");
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        runIdle(2);
        applyStimulus(1'b1, 1'b1, 3, 1'b0);
        runIdle(12);

        $display("[TB] run with stall in cycles 2-3");
        applyStimulus(1'b1, 1'b1, 3, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        runIdle(12);

        $display("[TB] zero-length run");
        applyStimulus(1'b1, 1'b1, 0, 1'b0);
        runIdle(4);

        $display("[TB] host_start during a run is ignored");
        applyStimulus(1'b1, 1'b1, 3, 1'b0);
        runIdle(3);
        applyStimulus(1'b1, 1'b1, 7, 1'b0);
        runIdle(6);
        applyStimulus(1'b1, 1'b1, 5, 1'b0);
        runIdle(16);

        $display("[TB] reset in the middle of a run");
        applyStimulus(1'b1, 1'b1, 3, 1'b0);
        runIdle(4);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        runIdle(4);

        $display("[TB] length 5 run");
        applyStimulus(1'b1, 1'b1, 5, 1'b0);
        runIdle(14);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 99) != 0),
                          ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 6)),
                          ($urandom_range(0, 3) == 0));
        end
        runIdle(20);

        @(negedge clk);
        @(negedge clk);
        cmpOne("scoreboard_drained", cyc, 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
